// File: rtl/prbs_pkg.sv
// Shared definitions for the 6-bit PRBS generator/checker pair.
// The update function lives here so both ends of the link use identical logic.
package prbs_pkg;

  localparam int PRBS_W = 6;
  localparam logic [PRBS_W-1:0] DEFAULT_POLY = 6'b101001;
  localparam logic [PRBS_W-1:0] PRBS_SEED    = 6'b000001;

  // Checker alignment FSM: hunting for phase, or aligned and counting errors.
  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } chk_state_e;

  // One LFSR step: shift left (dropping the old MSB), then fold the mask in
  // when the new top bit matches the mask's top bit.
  function automatic logic [PRBS_W-1:0] prbs_next(input logic [PRBS_W-1:0] state,
                                                  input logic [PRBS_W-1:0] poly);
    logic [PRBS_W-1:0] shifted;
    shifted = {state[PRBS_W-2:0], 1'b0};
    if (shifted[PRBS_W-1] == poly[PRBS_W-1]) begin
      return poly ^ shifted;
    end
    return shifted;
  endfunction

endpackage

// File: rtl/prbs_replica.sv
// Local replica of the transmit LFSR. It only steps when told to, so the
// checker can hold it for one bit to slip its phase against the stream.
module prbs_replica
  import prbs_pkg::*;
#(
  parameter logic [PRBS_W-1:0] POLY = DEFAULT_POLY
) (
  input  logic clk,
  input  logic reset,
  input  logic advance,
  output logic bit0
);

  logic [PRBS_W-1:0] lfsr;

  // Replica register: seed on reset, step on advance, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= PRBS_SEED;
    end else if (advance) begin
      lfsr <= prbs_next(lfsr, POLY);
    end
  end

  assign bit0 = lfsr[0];

endmodule

// File: rtl/prbs_checker.sv
// PRBS receive checker: aligns a replica LFSR to the incoming stream by
// slipping, declares lock after a run of matches, counts errors while locked
// and falls back to searching when too many errors land in one window.
//
// Handshake: rx_valid qualifies rx_bit for exactly the cycle it is high;
// there is no back-pressure (no ready), and cycles with rx_valid low are
// ignored entirely.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter logic [PRBS_W-1:0] POLY        = DEFAULT_POLY,
  parameter int                LOCK_THRESH = 16,
  parameter int                WINDOW      = 64,
  parameter int                UNLOCK_ERRS = 8,
  parameter int                ERR_W       = 16,
  parameter int                BIT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_bit,
  input  logic             rx_valid,
  input  logic             clear_counts,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [BIT_W-1:0] bit_count
);

  localparam logic [7:0] LOCK_LAST  = 8'(LOCK_THRESH - 1);
  localparam logic [9:0] WIN_LAST   = 10'(WINDOW - 1);
  localparam logic [9:0] UNLOCK_LIM = 10'(UNLOCK_ERRS);

  chk_state_e state;
  logic [7:0] match_cnt;
  logic [9:0] win_cnt;
  logic [9:0] win_err;
  logic [9:0] win_err_nxt;
  logic       exp_bit;
  logic       mismatch;
  logic       rep_adv;

  assign mismatch    = rx_bit ^ exp_bit;
  assign win_err_nxt = win_err + {9'd0, mismatch};
  // While searching, a mismatch holds the replica for one bit (a slip);
  // once locked the replica free-runs with the stream.
  assign rep_adv     = rx_valid && ((state == LOCKED) || !mismatch);

  prbs_replica #(.POLY(POLY)) u_replica (
    .clk    (clk),
    .reset  (reset),
    .advance(rep_adv),
    .bit0   (exp_bit)
  );

  // Alignment FSM plus the loss-of-lock window bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SEARCH;
      match_cnt <= 8'd0;
      win_cnt   <= 10'd0;
      win_err   <= 10'd0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (rx_valid) begin
        case (state)
          SEARCH: begin
            if (mismatch) begin
              match_cnt <= 8'd0;
            end else if (match_cnt == LOCK_LAST) begin
              state     <= LOCKED;
              match_cnt <= 8'd0;
              win_cnt   <= 10'd0;
              win_err   <= 10'd0;
            end else begin
              match_cnt <= match_cnt + 8'd1;
            end
          end
          default: begin
            err_pulse <= mismatch;
            // Loss-of-lock is judged on this bit before any window rollover.
            if (mismatch && (win_err_nxt == UNLOCK_LIM)) begin
              state     <= SEARCH;
              match_cnt <= 8'd0;
            end
            if (win_cnt == WIN_LAST) begin
              win_cnt <= 10'd0;
              win_err <= 10'd0;
            end else begin
              win_cnt <= win_cnt + 10'd1;
              win_err <= win_err_nxt;
            end
          end
        endcase
      end
    end
  end

  // Saturating statistics; a clear in the same cycle beats a counted bit.
  always_ff @(posedge clk) begin
    if (reset || clear_counts) begin
      err_count <= '0;
      bit_count <= '0;
    end else if (rx_valid && (state == LOCKED)) begin
      if (bit_count != '1) begin
        bit_count <= bit_count + BIT_W'(1);
      end
      if (mismatch && (err_count != '1)) begin
        err_count <= err_count + ERR_W'(1);
      end
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker. The transmit stream is a hand-derived
// table of one 31-bit period of the 6'b101001 generator starting at seed 1.
module tb_prbs_checker;

  localparam int ERR_W = 4;
  localparam int BIT_W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx_bit = 1'b0;
  logic rx_valid = 1'b0;
  logic clear_counts = 1'b0;
  logic locked;
  logic err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [BIT_W-1:0] bit_count;

  always #5 clk = ~clk;

  prbs_checker #(.ERR_W(ERR_W), .BIT_W(BIT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_bit      (rx_bit),
    .rx_valid    (rx_valid),
    .clear_counts(clear_counts),
    .locked      (locked),
    .err_pulse   (err_pulse),
    .err_count   (err_count),
    .bit_count   (bit_count)
  );

  // Generator output bits for states 1,2,4,8,16,9,18,13,26,29,19,15,30,21,3,
  // 6,12,24,25,27,31,23,7,14,28,17,11,22,5,10,20 (bit 0 of each state).
  localparam logic [0:30] SEQ = 31'b1000010101110110001111100110100;
  logic [0:30] seq;
  int gen_idx;

  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    logic v;
    logic f;
    logic c;
    logic lk;
    logic ep;
    logic [ERR_W-1:0] ec;
    logic [BIT_W-1:0] bc;
  } vec_t;
  vec_t tbl[28];

  function automatic vec_t mk(input logic v, input logic f, input logic c,
                              input logic lk, input logic ep, input int ec, input int bc);
    vec_t r;
    r.v  = v;
    r.f  = f;
    r.c  = c;
    r.lk = lk;
    r.ep = ep;
    r.ec = ERR_W'(ec);
    r.bc = BIT_W'(bc);
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Apply one cycle; flip inverts the transmitted bit. Outputs are sampled
  // 1 ns after the edge that consumed the bit.
  task automatic step(input logic v, input logic f, input logic c);
    rx_valid     = v;
    rx_bit       = v ? (seq[gen_idx] ^ f) : 1'b0;
    clear_counts = c;
    @(posedge clk);
    if (v) gen_idx = (gen_idx + 1) % 31;
    #1;
  endtask

  // Reset the checker; the generator restarts at start_idx (phase offset).
  task automatic do_reset(input int start_idx);
    reset        = 1'b1;
    rx_valid     = 1'b1;
    rx_bit       = 1'b1;
    clear_counts = 1'b0;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    gen_idx = start_idx;
  endtask

  // Run matching bits until lock; returns the number of valid bits used.
  task automatic run_to_lock(input int max_cycles, input logic gappy, output int nvalid);
    logic v;
    nvalid = 0;
    for (int i = 0; i < max_cycles; i++) begin
      v = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
      step(v, 1'b0, 1'b0);
      if (v) nvalid++;
      if (locked) break;
    end
  endtask

  initial begin
    int nv;
    int bad;
    int nerr;
    int cnt;
    logic v;
    logic f;
    seq = SEQ;
    gen_idx = 0;

    // Table: lock from reset, single error, gaps, clear interactions.
    for (int i = 0; i < 15; i++) tbl[i] = mk(1, 0, 0, 0, 0, 0, 0);
    tbl[15] = mk(1, 0, 0, 1, 0, 0, 0);
    for (int i = 16; i < 20; i++) tbl[i] = mk(1, 0, 0, 1, 0, 0, i - 15);
    tbl[20] = mk(1, 1, 0, 1, 1, 1, 5);
    tbl[21] = mk(1, 0, 0, 1, 0, 1, 6);
    tbl[22] = mk(0, 0, 0, 1, 0, 1, 6);
    tbl[23] = mk(1, 1, 1, 1, 1, 0, 0);
    tbl[24] = mk(1, 0, 1, 1, 0, 0, 0);
    tbl[25] = mk(1, 0, 0, 1, 0, 0, 1);
    tbl[26] = mk(0, 1, 0, 1, 0, 0, 1);
    tbl[27] = mk(1, 0, 0, 1, 0, 0, 2);

    do_reset(0);
    check("reset_locked", 32'(locked), 0);
    check("reset_err_pulse", 32'(err_pulse), 0);
    check("reset_err_count", 32'(err_count), 0);
    check("reset_bit_count", bit_count, 0);

    for (int i = 0; i < 28; i++) begin
      step(tbl[i].v, tbl[i].f, tbl[i].c);
      check($sformatf("row%0d_locked", i), 32'(locked), 32'(tbl[i].lk));
      check($sformatf("row%0d_err_pulse", i), 32'(err_pulse), 32'(tbl[i].ep));
      check($sformatf("row%0d_err_count", i), 32'(err_count), 32'(tbl[i].ec));
      check($sformatf("row%0d_bit_count", i), bit_count, tbl[i].bc);
    end

    // Reset mid-lock with an erroring valid bit present: everything clears.
    reset = 1'b1; rx_valid = 1'b1; rx_bit = ~seq[gen_idx]; clear_counts = 1'b0;
    @(posedge clk);
    #1;
    check("midlock_reset_locked", 32'(locked), 0);
    check("midlock_reset_err_pulse", 32'(err_pulse), 0);
    check("midlock_reset_err_count", 32'(err_count), 0);
    check("midlock_reset_bit_count", bit_count, 0);
    reset = 1'b0;
    gen_idx = 0;

    // Lock sequence repeats: locked low after bit 15, high after bit 16.
    for (int i = 1; i <= 16; i++) begin
      step(1, 0, 0);
      if (i == 15) check("relock_bit15_locked", 32'(locked), 0);
      if (i == 16) check("relock_bit16_locked", 32'(locked), 1);
    end

    // Burst of 8 consecutive errors: lock falls on the 8th.
    for (int k = 1; k <= 8; k++) begin
      step(1, 1, 0);
      check($sformatf("burst%0d_err_pulse", k), 32'(err_pulse), 1);
      check($sformatf("burst%0d_err_count", k), 32'(err_count), 32'(k));
      check($sformatf("burst%0d_locked", k), 32'(locked), (k < 8) ? 32'd1 : 32'd0);
    end
    check("burst_bit_count", bit_count, 8);
    // Replica stayed aligned, so 16 good bits re-lock with no new errors.
    bad = 0;
    for (int j = 1; j <= 16; j++) begin
      step(1, 0, 0);
      if (err_pulse !== 1'b0 || err_count !== 4'd8 || bit_count !== 32'd8) bad++;
      if (j == 15) check("burst_relock15_locked", 32'(locked), 0);
      if (j == 16) check("burst_relock16_locked", 32'(locked), 1);
    end
    check("burst_search_quiet", 32'(bad), 0);

    // 1000 clean locked bits after a clear that coincides with a counted bit.
    step(1, 0, 1);
    check("clear_beats_bit_bit_count", bit_count, 0);
    bad = 0;
    for (int j = 1; j <= 1000; j++) begin
      step(1, 0, 0);
      if (err_pulse !== 1'b0 || bit_count !== 32'(j) || locked !== 1'b1) bad++;
    end
    check("clean1000_bad_cycles", 32'(bad), 0);
    check("clean1000_err_count", 32'(err_count), 0);
    check("clean1000_bit_count", bit_count, 1000);

    // Phase offset: generator 20 bits ahead of the checker.
    do_reset(20);
    run_to_lock(2000, 1'b0, nv);
    check("offset_locked", 32'(locked), 1);
    bad = 0;
    for (int j = 0; j < 200; j++) begin
      step(1, 0, 0);
      if (err_pulse !== 1'b0 || locked !== 1'b1) bad++;
    end
    check("offset_bad_cycles", 32'(bad), 0);
    check("offset_err_count", 32'(err_count), 0);

    // Gapped stream: lock needs exactly 16 valid bits; bit_count tracks valids.
    do_reset(0);
    run_to_lock(1000, 1'b1, nv);
    check("gaps_locked", 32'(locked), 1);
    check("gaps_valid_bits_to_lock", 32'(nv), 16);
    cnt = 0;
    bad = 0;
    for (int j = 0; j < 300; j++) begin
      v = 1'($urandom_range(0, 1));
      step(v, 0, 0);
      if (v) cnt++;
      if (err_pulse !== 1'b0) bad++;
    end
    check("gaps_bit_count", bit_count, 32'(cnt));
    check("gaps_err_pulses", 32'(bad), 0);
    check("gaps_err_count", 32'(err_count), 0);
    step(1, 1, 1);
    check("clear_with_error_err_pulse", 32'(err_pulse), 1);
    check("clear_with_error_err_count", 32'(err_count), 0);
    step(1, 0, 0);
    check("after_clear_err_count", 32'(err_count), 0);

    // Saturation and window boundaries: 7 errors at the end of window 0,
    // one at the start of windows 1..11 (never 8 in one window), then
    // 8 spaced errors inside window 12 force loss of lock.
    do_reset(0);
    run_to_lock(100, 1'b0, nv);
    check("sat_locked", 32'(locked), 1);
    nerr = 0;
    bad = 0;
    for (int p = 0; p < 12 * 64 + 15; p++) begin
      f = ((p / 64 == 0) && (p % 64 >= 57)) ||
          ((p / 64 >= 1) && (p / 64 <= 11) && (p % 64 == 0)) ||
          ((p / 64 == 12) && (p % 64 < 15) && (p % 2 == 0));
      step(1, f, 0);
      if (f) nerr++;
      if (err_count !== ERR_W'((nerr > 15) ? 15 : nerr)) bad++;
      if (p == 64) check("sat_window_boundary_locked", 32'(locked), 1);
      if (p == 12 * 64 - 1) begin
        check("sat_before_unlock_locked", 32'(locked), 1);
        check("sat_err_count_held", 32'(err_count), 15);
      end
    end
    check("sat_err_count_trace", 32'(bad), 0);
    check("sat_err_count_final", 32'(err_count), 15);
    check("sat_spaced_unlock", 32'(locked), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Receive-side companion to the 6-bit PRBS generator; sits directly downstream of it and consumes its serial pseudo-random bit stream.
- Runs a local replica LFSR with the same update rule as the generator.
- Aligns the replica to the incoming stream by slipping, declares lock, and counts bit errors while locked.
- Drops lock on an error burst, then re-acquires without software intervention.

Parameters:
- POLY, 6'b101001, feedback mask; must equal the generator's mask.
- LOCK_THRESH, 16, consecutive matching valid bits required to declare lock (1..255).
- WINDOW, 64, valid-bit window length for the loss-of-lock check (2..1023).
- UNLOCK_ERRS, 8, errors within one window that force loss of lock (1..WINDOW).
- ERR_W, 16, width of err_count.
- BIT_W, 32, width of bit_count.

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- rx_bit, in, 1, received PRBS bit; connects to the generator's pseudo_rand_bit.
- rx_valid, in, 1, rx_bit is sampled this cycle; tie to 1 for a continuous stream.
- clear_counts, in, 1, synchronous clear of err_count and bit_count.
- locked, out, 1, replica is aligned.
- err_pulse, out, 1, one-cycle pulse per mismatched bit while locked.
- err_count, out, ERR_W, saturating error count.
- bit_count, out, BIT_W, saturating count of valid bits checked while locked.

Behaviour:
- Interface: clock clk; reset reset, synchronous, active-high.
- Replica update rule: shifted = state<<1, truncated to 6 bits. If shifted[5]==POLY[5], next = POLY^shifted; else next = shifted. Expected bit = state[0]. Replica reset value is 6'b000001.
- Reset: state=SEARCH, replica=1, match_cnt=0, win_cnt=0, win_err=0, locked=0, err_pulse=0, err_count=0, bit_count=0. Reset overrides every other input, including mid-lock.
- All outputs are registered. For a bit sampled at edge N, its effect on locked, err_pulse, err_count and bit_count is visible after edge N (1-cycle latency).
- rx_valid=0: nothing advances or changes, and err_pulse=0.
- SEARCH, on each valid bit:
  - Match: replica advances, match_cnt++.
  - Match with match_cnt reaching LOCK_THRESH: go to LOCKED, locked=1, win_cnt=win_err=0.
  - Mismatch: replica holds one cycle (slip), match_cnt=0.
  - No error counting in SEARCH; err_pulse stays 0.
- LOCKED, on each valid bit:
  - Replica always advances; bit_count++, saturating at all-ones.
  - Mismatch: err_pulse=1, err_count++ saturating at all-ones, win_err++.
  - win_cnt++. When win_cnt reaches WINDOW, win_cnt=win_err=0, applied after the UNLOCK check for that bit.
  - win_err reaching UNLOCK_ERRS on this bit: go to SEARCH, locked=0, match_cnt=0; replica keeps its current value.
- clear_counts:
  - Zeroes err_count and bit_count.
  - Same cycle as a counted bit: the clear wins and the bit is not counted.
  - Does not affect the FSM, the replica or err_pulse.
- Saturated counters hold until clear_counts or reset.
- An all-zero replica state is unreachable from reset; no escape logic is required.

Decomposition:
- Package prbs_pkg holds:
  - PRBS_W=6, DEFAULT_POLY=6'b101001, PRBS_SEED=6'b000001.
  - FSM state typedef {SEARCH, LOCKED}.
  - function prbs_next(state, poly) implementing the update rule; shared with the generator so both sides stay identical.
- One sub-module: prbs_replica, containing the 6-bit register, an advance enable, the prbs_next function and a bit0 output.
- The FSM, window logic and counters stay in the top module.

Test Plan:
- Lock from reset: generator and checker leave reset together with rx_valid=1 → locked rises after edge 16. err_count=0 and err_pulse never asserts over 1000 bits, and bit_count increments once per bit after lock.
- Single error: after lock, invert one rx_bit → err_pulse high for exactly 1 cycle on the next edge, err_count=1, locked stays 1, and later bits match again.
- Burst: after lock, invert 8 consecutive bits → err_count=8 and locked falls after the 8th error. The checker re-locks within 16 matching bits after the burst with no further err_count change.
- Phase offset: start the generator 20 cycles before the checker leaves reset → locked asserts within 2000 valid bits, with no errors counted afterwards.
- Gaps and clear: toggle rx_valid randomly at 50% → same lock and zero-error result, and bit_count equals the number of valid locked bits. Pulse clear_counts together with an injected error → err_count=0 afterwards.
- Saturation and reset: with ERR_W=4 and errors spread one per window (UNLOCK_ERRS=8), err_count reaches 15 and holds. Assert reset mid-lock → all outputs 0 on the next edge and the lock sequence repeats.
